// File: rtl/mm_seq_pkg.sv
// mm_seq_pkg: shared step-code width, "no step" code and sequencer state type
package mm_seq_pkg;
  localparam int STEP_W = 4;
  localparam logic [STEP_W-1:0] STEP_NONE = 4'd0;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} seq_state_e;
endpackage

// File: rtl/mm_step_sequencer.sv
// mm_step_sequencer: step/pass sequencer for the matmul datapath; ports clk, rst_n(async low), start, stall, abort -> step_code, iter_idx, busy, done; MM_SEQ_SINGLE_STEP_EN adds dbg_mode, dbg_step
module mm_step_sequencer
  import mm_seq_pkg::*;
#(
  parameter int NUM_STEPS = 15,
  parameter int NUM_ITERS = 4,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              abort,
`ifdef MM_SEQ_SINGLE_STEP_EN
  input  logic              dbg_mode,
  input  logic              dbg_step,
`endif
  output logic [STEP_W-1:0] step_code,
  output logic [ITER_W-1:0] iter_idx,
  output logic              busy,
  output logic              done
);
  seq_state_e state, state_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [ITER_W-1:0] iter_n;
  logic hold_req, last_step, last_iter;
`ifdef MM_SEQ_SINGLE_STEP_EN
  assign hold_req = stall | (dbg_mode & ~dbg_step);
`else
  assign hold_req = stall;
`endif
  assign last_step = step_q == STEP_W'(NUM_STEPS);
  assign last_iter = iter_idx == ITER_W'(NUM_ITERS - 1);
  always_comb begin
    state_n = state;
    step_n = step_q;
    iter_n = iter_idx;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        step_n = 4'd1;
        iter_n = '0;
      end
      RUN: begin
        step_n = last_step ? 4'd1 : step_q + 4'd1;
        iter_n = last_step ? (last_iter ? '0 : iter_idx + ITER_W'(1)) : iter_idx;
        state_n = (last_step && last_iter) ? DONE : hold_req ? HOLD : RUN;
      end
      HOLD: state_n = hold_req ? HOLD : RUN;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      step_n = 4'd1;
      iter_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step_q <= 4'd1;
      step_code <= STEP_NONE;
      iter_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      step_q <= step_n;
      step_code <= (state_n == RUN) ? step_n : STEP_NONE;
      iter_idx <= iter_n;
      busy <= (state_n == RUN) || (state_n == HOLD);
      done <= state_n == DONE;
    end
endmodule
